alu_issue_stage: RTL and testbench

//  Issue stage directly upstream of the ALU. Accepts decoded operations from decode over a valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue stage in front of the ALU. Takes decoded ops from decode over a
//   valid/ready handshake, picks operand B (register or immediate), derives
//   the ALU select code, and presents registered operands to the ALU through
//   a 2-entry skid buffer so in_ready never depends combinationally on EX.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous discard of all buffered ops
//   in_valid/in_ready decode handshake (in_ready is registered)
//   in_rs1/in_rs2     register operands
//   in_imm            sign-extended immediate
//   in_alusrc         1 selects in_imm as src2
//   in_aluop/in_funct3/in_funct7b5/in_opb5  select decode inputs
//   out_valid/out_ready  EX handshake
//   src1/src2/sel     ALU operands and select (AND=0 OR=1 ADD=2 SUB=6 SLT=7)
//   illegal           op had an unsupported encoding; travels with the op
//
// State   | meaning
// --------+-------------------------------------------------------
// EMPTY   | nothing buffered, out_valid=0
// ONE     | output register holds an op
// TWO     | output and skid registers both hold ops, in_ready=0
`timescale 1ns/1ps
module alu_issue_stage #(
  parameter int DWIDTH = 8,
  parameter int SWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_rs1,
  input  logic [DWIDTH-1:0] in_rs2,
  input  logic [DWIDTH-1:0] in_imm,
  input  logic              in_alusrc,
  input  logic [1:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic              in_opb5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] src1,
  output logic [DWIDTH-1:0] src2,
  output logic [SWIDTH-1:0] sel,
  output logic              illegal
);

  localparam logic [SWIDTH-1:0] SEL_AND = SWIDTH'(0);
  localparam logic [SWIDTH-1:0] SEL_OR  = SWIDTH'(1);
  localparam logic [SWIDTH-1:0] SEL_ADD = SWIDTH'(2);
  localparam logic [SWIDTH-1:0] SEL_SUB = SWIDTH'(6);
  localparam logic [SWIDTH-1:0] SEL_SLT = SWIDTH'(7);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t state_q, state_d;
  logic   in_ready_q;
  logic   accept, consume;
  logic   load_out, load_skid, move_skid;

  logic [SWIDTH-1:0] dec_sel;
  logic              dec_ill;
  logic [DWIDTH-1:0] in_src2;

  logic [DWIDTH-1:0] skid_src1, skid_src2;
  logic [SWIDTH-1:0] skid_sel;
  logic              skid_ill;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;
  assign in_src2   = in_alusrc ? in_imm : in_rs2;

  always_comb begin
    dec_sel = SEL_ADD;
    dec_ill = 1'b0;
    case (in_aluop)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      2'b10: begin
        case (in_funct3)
          3'b000:  dec_sel = (in_opb5 & in_funct7b5) ? SEL_SUB : SEL_ADD;
          3'b010:  dec_sel = SEL_SLT;
          3'b110:  dec_sel = SEL_OR;
          3'b111:  dec_sel = SEL_AND;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d   = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any transfer in the same cycle; the offered op is dropped.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      src1       <= '0;
      src2       <= '0;
      sel        <= '0;
      illegal    <= 1'b0;
      skid_src1  <= '0;
      skid_src2  <= '0;
      skid_sel   <= '0;
      skid_ill   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (load_out) begin
        src1    <= in_rs1;
        src2    <= in_src2;
        sel     <= dec_sel;
        illegal <= dec_ill;
      end else if (move_skid) begin
        src1    <= skid_src1;
        src2    <= skid_src2;
        sel     <= skid_sel;
        illegal <= skid_ill;
      end
      if (load_skid) begin
        skid_src1 <= in_rs1;
        skid_src2 <= in_src2;
        skid_sel  <= dec_sel;
        skid_ill  <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_rs1, in_rs2, in_imm;
  logic       in_alusrc;
  logic [1:0] in_aluop;
  logic [2:0] in_funct3;
  logic       in_funct7b5, in_opb5;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] src1, src2;
  logic [2:0] sel;
  logic       illegal;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [2:0] sel;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DWIDTH(8), .SWIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5), .in_opb5(in_opb5),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1(src1), .src2(src2), .sel(sel), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode: AND=0 OR=1 ADD=2 SUB=6 SLT=7
  function automatic exp_t model();
    exp_t e;
    e.s1  = in_rs1;
    e.s2  = in_alusrc ? in_imm : in_rs2;
    e.sel = 3'd2;
    e.ill = 1'b0;
    if (in_aluop == 2'b01) e.sel = 3'd6;
    else if (in_aluop == 2'b11) e.ill = 1'b1;
    else if (in_aluop == 2'b10) begin
      if (in_funct3 == 3'b000)      e.sel = (in_opb5 && in_funct7b5) ? 3'd6 : 3'd2;
      else if (in_funct3 == 3'b010) e.sel = 3'd7;
      else if (in_funct3 == 3'b110) e.sel = 3'd1;
      else if (in_funct3 == 3'b111) e.sel = 3'd0;
      else                          e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock: compare outputs against scoreboard at the falling edge,
  // update the scoreboard for this cycle's transfers, then advance past the
  // rising edge.
  task automatic step();
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (out_valid && exp_q.size() > 0) begin
      chk("src1", 32'(src1), 32'(exp_q[0].s1));
      chk("src2", 32'(src2), 32'(exp_q[0].s2));
      chk("sel", 32'(sel), 32'(exp_q[0].sel));
      chk("illegal", 32'(illegal), 32'(exp_q[0].ill));
    end
    if (flush) exp_q.delete();
    else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] rs1, input logic [7:0] rs2, input logic [7:0] imm,
                        input logic alusrc, input logic [1:0] aluop, input logic [2:0] f3,
                        input logic f7, input logic opb5);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_alusrc   = alusrc;
    in_aluop    = aluop;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_opb5     = opb5;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_alusrc = 1'b0;
    in_aluop = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_opb5 = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_src1", 32'(src1), 32'd0);
    chk("rst_src2", 32'(src2), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // 1: R-type SUB
    set_op(8'h0A, 8'h03, 8'h00, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sel", 32'(sel), 32'd6);
    chk("t1_src2", 32'(src2), 32'h03);
    drain();

    // 2: funct3 decode, immediate operand, illegal encodings
    set_op(8'h11, 8'h22, 8'hF0, 1'b1, 2'b10, 3'b110, 1'b0, 1'b0); step();
    in_valid = 1'b0;
    chk("t2_or_sel", 32'(sel), 32'd1);
    chk("t2_imm_src2", 32'(src2), 32'hF0);
    set_op(8'h33, 8'h44, 8'h0F, 1'b0, 2'b10, 3'b111, 1'b0, 1'b0); step();
    set_op(8'h55, 8'h66, 8'h01, 1'b0, 2'b10, 3'b010, 1'b0, 1'b1); step();
    set_op(8'h77, 8'h88, 8'h02, 1'b0, 2'b10, 3'b001, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    chk("t2_ill_sel", 32'(sel), 32'd2);
    chk("t2_ill_flag", 32'(illegal), 32'd1);
    set_op(8'h99, 8'hAA, 8'h03, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0); step();
    set_op(8'hBB, 8'hCC, 8'h04, 1'b0, 2'b01, 3'b111, 1'b0, 1'b0); step();
    set_op(8'hDD, 8'hEE, 8'h05, 1'b0, 2'b10, 3'b000, 1'b1, 1'b0); step();
    drain();

    // 3: backpressure fills the skid buffer, then drains in order
    out_ready = 1'b0;
    set_op(8'hA1, 8'hA2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0); step();
    set_op(8'hB1, 8'hB2, 8'h00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0); step();
    set_op(8'hC1, 8'hC2, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
    step(); step();
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    chk("t3_hold_A", 32'(src1), 32'hA1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_then_B", 32'(src1), 32'hB1);
    drain();
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);

    // 4: 8 back-to-back ops at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    drain();

    // 5: flush from state TWO with an op offered
    out_ready = 1'b0;
    set_op(8'h01, 8'h02, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0); step();
    set_op(8'h03, 8'h04, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0); step();
    chk("t5_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_ready", 32'(in_ready), 32'd1);
    set_op(8'h5A, 8'h00, 8'h00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0); step();
    in_valid = 1'b0;
    chk("t5_new_op", 32'(src1), 32'h5A);
    drain();

    // 6: asynchronous reset while in state TWO
    out_ready = 1'b0;
    set_op(8'h61, 8'h62, 8'h00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0); step();
    set_op(8'h71, 8'h72, 8'h00, 1'b0, 2'b10, 3'b111, 1'b0, 1'b0); step();
    in_valid = 1'b0;
    chk("t6_in_two", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_sel", 32'(sel), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    set_op(8'h81, 8'h82, 8'h00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0); step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
